// File: rtl/dmem_controller.sv
// Data-memory front-end: core/debug round-robin arbitration, sub-word stores as RMW, load extension.
// Optional debug port and arbitration enabled by defining DMEM_CTRL_DBG_PORT_EN.
package pkg_config;
  parameter int DATA_WIDTH = 32;
endpackage

module dmem_controller #(
  parameter int DATA_WIDTH = pkg_config::DATA_WIDTH,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  c_req_i,
  input  logic                  c_we_i,
  input  logic [1:0]            c_size_i,
  input  logic                  c_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic [DATA_WIDTH-1:0] c_wdata_i,
  output logic                  c_gnt_o,
  output logic                  c_rvalid_o,
  output logic [DATA_WIDTH-1:0] c_rdata_o,
  output logic                  c_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, MERGE_WR = 2'd2} state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_e                state_q, state_d;
  logic                  src_q, src_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  c_rvalid_q, c_rvalid_d;
  logic                  c_err_q, c_err_d;
  logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic                  c_win, d_win, c_gnt, d_gnt, c_bad, mem_we;
  logic [DATA_WIDTH-1:0] lane_word, load_fmt, merged;
  logic                  unused_bits;

  assign c_bad = (c_size_i == 2'b11)
              || ((c_size_i == SizeHalf) && c_addr_i[0])
              || ((c_size_i == SizeWord) && (c_addr_i[1:0] != 2'b00));

`ifdef DMEM_CTRL_DBG_PORT_EN
  // rr_last_q = 1 when the debug port was granted last; reset favours the core
  logic rr_last_q, rr_last_d;

  assign c_win = c_req_i && (!d_req_i || rr_last_q);
  assign d_win = d_req_i && (!c_req_i || !rr_last_q);

  always_comb begin
    rr_last_d = rr_last_q;
    if (c_gnt) begin
      rr_last_d = 1'b0;
    end else if (d_gnt) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign d_gnt_o     = d_gnt;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign unused_bits = ^d_addr_i[1:0];
`else
  assign c_win       = c_req_i;
  assign d_win       = 1'b0;
  assign d_gnt_o     = 1'b0;
  assign d_rvalid_o  = 1'b0;
  assign d_rdata_o   = '0;
  assign unused_bits = ^{d_req_i, d_addr_i[1:0], d_rvalid_q, d_rdata_q};
`endif

  assign c_gnt = rst_ni && (state_q == IDLE) && c_win;
  assign d_gnt = rst_ni && (state_q == IDLE) && d_win;

  // Half-word lanes are 16-bit aligned, so one byte-granular shift serves both sizes
  always_comb begin
    lane_word = mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      SizeByte: load_fmt = {{(DATA_WIDTH-8){~uns_q & lane_word[7]}}, lane_word[7:0]};
      SizeHalf: load_fmt = {{(DATA_WIDTH-16){~uns_q & lane_word[15]}}, lane_word[15:0]};
      default:  load_fmt = mem_rdata_i;
    endcase
    merged = mem_rdata_i;
    if (size_q == SizeByte) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    c_rvalid_d = 1'b0;
    c_err_d    = 1'b0;
    c_rdata_d  = '0;
    d_rvalid_d = 1'b0;
    d_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (c_gnt) begin
          src_d   = 1'b0;
          we_d    = c_we_i;
          size_d  = c_size_i;
          uns_d   = c_unsigned_i;
          addr_d  = c_addr_i;
          wdata_d = c_wdata_i;
          err_d   = c_bad;
          state_d = ACCESS;
        end else if (d_gnt) begin
          src_d   = 1'b1;
          we_d    = d_we_i;
          size_d  = SizeWord;
          uns_d   = 1'b0;
          addr_d  = {d_addr_i[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = d_wdata_i;
          err_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (err_q) begin
          c_rvalid_d = 1'b1;
          c_err_d    = 1'b1;
        end else if (we_q && (size_q != SizeWord)) begin
          wdata_d = merged;
          state_d = MERGE_WR;
        end else if (src_q) begin
          d_rvalid_d = 1'b1;
          if (!we_q) d_rdata_d = mem_rdata_i;
        end else begin
          c_rvalid_d = 1'b1;
          if (!we_q) c_rdata_d = load_fmt;
        end
      end
      MERGE_WR: begin
        state_d    = IDLE;
        c_rvalid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      src_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      c_rvalid_q <= c_rvalid_d;
      c_err_q    <= c_err_d;
      c_rdata_q  <= c_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Write strobe comes straight from registered state so an async reset kills it at once
  assign mem_we = (state_q == MERGE_WR)
               || ((state_q == ACCESS) && we_q && !err_q && (size_q == SizeWord));

  assign mem_we_o    = mem_we;
  assign mem_addr_o  = (state_q == IDLE) ? '0 : {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = mem_we ? wdata_q : '0;
  assign c_gnt_o     = c_gnt;
  assign c_rvalid_o  = c_rvalid_q;
  assign c_err_o     = c_err_q;
  assign c_rdata_o   = c_rdata_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Directed self-checking bench for dmem_controller with a behavioural word memory.
// Debug-port steps follow DMEM_CTRL_DBG_PORT_EN; otherwise the d_* port is checked as ignored.
module tb_dmem_controller;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk, rstN;
  logic          cReq, cWe, cUns, cGnt, cRvalid, cErr;
  logic [1:0]    cSize;
  logic [AW-1:0] cAddr;
  logic [DW-1:0] cWdata, cRdata;
  logic          dReq, dWe, dGnt, dRvalid;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata, dRdata;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata, memRdata;

  logic [DW-1:0] tbMem [0:1023];
  logic          bdEn;
  logic [9:0]    bdIdx;
  logic [DW-1:0] bdData;

  int compared = 0;
  int mismatched = 0;

  logic [2:0]    obsWe, obsCv, obsCe, obsDv;
  logic [DW-1:0] obsWdata [1:3];
  logic [DW-1:0] obsAddr  [1:3];
  logic [DW-1:0] obsCdata [1:3];
  logic [DW-1:0] obsDdata [1:3];
  logic [5:0]    seqCg, seqDg, seqCv, seqDv;
  logic [DW-1:0] seqCd [0:5];
  logic [DW-1:0] seqDd [0:5];
  logic          sawRvalid;

  dmem_controller #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .c_req_i(cReq), .c_we_i(cWe), .c_size_i(cSize), .c_unsigned_i(cUns),
    .c_addr_i(cAddr), .c_wdata_i(cWdata),
    .c_gnt_o(cGnt), .c_rvalid_o(cRvalid), .c_rdata_o(cRdata), .c_err_o(cErr),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata),
    .d_gnt_o(dGnt), .d_rvalid_o(dRvalid), .d_rdata_o(dRdata),
    .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory with combinational read; a backdoor port preloads it while the DUT is idle
  assign memRdata = tbMem[memAddr[11:2]];
  always @(posedge clk) begin
    if (memWe) tbMem[memAddr[11:2]] <= memWdata;
    else if (bdEn) tbMem[bdIdx] <= bdData;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input logic [9:0] idx, input logic [DW-1:0] data);
    @(negedge clk);
    bdEn = 1'b1; bdIdx = idx; bdData = data;
    @(negedge clk);
    bdEn = 1'b0;
  endtask

  // Issues one request, waits (bounded) for its grant, then records the three cycles after it
  task automatic applyStimulus(input logic isDbg, input logic we, input logic [1:0] size,
                               input logic uns, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int waitCnt;
    logic granted;
    @(negedge clk);
    if (isDbg) begin
      dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wdata;
    end else begin
      cReq = 1'b1; cWe = we; cSize = size; cUns = uns; cAddr = addr; cWdata = wdata;
    end
    #1;
    waitCnt = 0;
    granted = isDbg ? dGnt : cGnt;
    while (!granted && waitCnt < 20) begin
      @(negedge clk); #1;
      waitCnt++;
      granted = isDbg ? dGnt : cGnt;
    end
    checkOutput("grant", {31'd0, granted}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin cReq = 1'b0; dReq = 1'b0; end
      #1;
      obsWe[k-1] = memWe;   obsWdata[k] = memWdata; obsAddr[k] = {20'd0, memAddr};
      obsCv[k-1] = cRvalid; obsCe[k-1]  = cErr;     obsCdata[k] = cRdata;
      obsDv[k-1] = dRvalid; obsDdata[k] = dRdata;
    end
  endtask

  task automatic checkLoad(input string tag, input logic [DW-1:0] exp);
    checkOutput({tag, ".rvalid"}, {29'd0, obsCv}, 32'b010);
    checkOutput({tag, ".err"},    {29'd0, obsCe}, 32'd0);
    checkOutput({tag, ".we"},     {29'd0, obsWe}, 32'd0);
    checkOutput({tag, ".data"},   obsCdata[2], exp);
  endtask

  task automatic checkError(input string tag);
    checkOutput({tag, ".rvalid"}, {29'd0, obsCv}, 32'b010);
    checkOutput({tag, ".err"},    {29'd0, obsCe}, 32'b010);
    checkOutput({tag, ".we"},     {29'd0, obsWe}, 32'd0);
    checkOutput({tag, ".data"},   obsCdata[2], 32'd0);
  endtask

  initial begin
    cReq = 0; cWe = 0; cSize = 0; cUns = 0; cAddr = 0; cWdata = 0;
    dReq = 0; dWe = 0; dAddr = 0; dWdata = 0;
    bdEn = 0; bdIdx = 0; bdData = 0;
    rstN = 1'b0;

    // Reset state, with a core request held to show no grant leaks out during reset
    repeat (2) @(negedge clk);
    cReq = 1'b1; cSize = 2'b10; dReq = 1'b1;
    #1;
    checkOutput("rst.flags", {26'd0, cGnt, cRvalid, cErr, dGnt, dRvalid, memWe}, 32'd0);
    checkOutput("rst.crdata", cRdata, 32'd0);
    checkOutput("rst.drdata", dRdata, 32'd0);
    checkOutput("rst.memaddr", {20'd0, memAddr}, 32'd0);
    checkOutput("rst.memwdata", memWdata, 32'd0);
    @(negedge clk);
    cReq = 1'b0; dReq = 1'b0; rstN = 1'b1;

`ifdef DMEM_CTRL_DBG_PORT_EN
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344);
    checkOutput("dbgwr.we",     {29'd0, obsWe}, 32'b001);
    checkOutput("dbgwr.wdata",  obsWdata[1], 32'h11223344);
    checkOutput("dbgwr.drv",    {29'd0, obsDv}, 32'b010);
    checkOutput("dbgwr.crv",    {29'd0, obsCv}, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 12'h013, 32'h0);
    checkOutput("dbgrd.addr",   obsAddr[1], 32'h010);
    checkOutput("dbgrd.drv",    {29'd0, obsDv}, 32'b010);
    checkOutput("dbgrd.data",   obsDdata[2], 32'h11223344);
`else
    backdoor(10'd4, 32'h11223344);
    @(negedge clk);
    dReq = 1'b1; dWe = 1'b1; dAddr = 12'h010; dWdata = 32'hFFFFFFFF;
    sawRvalid = 1'b0;
    repeat (3) begin
      #1;
      sawRvalid = sawRvalid | dGnt | dRvalid | memWe | (|dRdata);
      @(negedge clk);
    end
    checkOutput("nodbg.ignored", {31'd0, sawRvalid}, 32'd0);
`endif
    checkOutput("mem.w4", tbMem[4], 32'h11223344);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
    checkLoad("lb013", 32'h00000011);
    checkOutput("lb013.addr", obsAddr[1], 32'h010);
    checkOutput("lb013.idleaddr", obsAddr[2], 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 12'h010, 32'h0);
    checkLoad("lb010", 32'h00000044);

    // Sub-word store: read in N+1, write in N+2, completion in N+3
    backdoor(10'd8, 32'h000000F0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 12'h021, 32'h1234565A);
    checkOutput("sb021.we",     {29'd0, obsWe}, 32'b010);
    checkOutput("sb021.wdata",  obsWdata[2], 32'h00005AF0);
    checkOutput("sb021.addr",   obsAddr[2], 32'h020);
    checkOutput("sb021.rvalid", {29'd0, obsCv}, 32'b100);
    checkOutput("sb021.rdata",  obsCdata[3], 32'h0);
    checkOutput("mem.w8",       tbMem[8], 32'h00005AF0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 12'h021, 32'h0);
    checkLoad("lb021", 32'h0000005A);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 12'h020, 32'h0);
    checkLoad("lbu020", 32'h000000F0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 12'h020, 32'h0);
    checkLoad("lb020", 32'hFFFFFFF0);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 12'h020, 32'h0);
    checkLoad("lh020", 32'h00005AF0);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 12'h022, 32'hAAAABEEF);
    checkOutput("sh022.wdata",  obsWdata[2], 32'hBEEF5AF0);
    checkOutput("sh022.rvalid", {29'd0, obsCv}, 32'b100);

    backdoor(10'd12, 32'h8000FF80);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 12'h032, 32'h0);
    checkLoad("lh032", 32'hFFFF8000);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b1, 12'h032, 32'h0);
    checkLoad("lhu032", 32'h00008000);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 12'h030, 32'h0);
    checkLoad("lb030", 32'hFFFFFF80);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 12'h031, 32'h0);
    checkLoad("lbu031", 32'h000000FF);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 12'h030, 32'h0);
    checkLoad("lw030", 32'h8000FF80);

    // Misaligned and illegal accesses complete with err and never write
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 12'h006, 32'h0);
    checkError("lw006");
    applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 12'h008, 32'h0);
    checkError("sz11ld");
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 12'h008, 32'hCAFEF00D);
    checkError("sz11st");
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 12'h041, 32'h0000CAFE);
    checkError("sh041");

    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 12'h050, 32'hDEADBEEF);
    checkOutput("sw050.we",     {29'd0, obsWe}, 32'b001);
    checkOutput("sw050.wdata",  obsWdata[1], 32'hDEADBEEF);
    checkOutput("sw050.rvalid", {29'd0, obsCv}, 32'b010);
    checkOutput("sw050.rdata",  obsCdata[2], 32'h0);
    checkOutput("mem.w20",      tbMem[20], 32'hDEADBEEF);

    // Reset during the write half of an RMW discards it
    backdoor(10'd16, 32'h12345678);
    @(negedge clk);
    cReq = 1'b1; cWe = 1'b1; cSize = 2'b01; cUns = 1'b0; cAddr = 12'h040; cWdata = 32'h0000BEEF;
    #1;
    checkOutput("rmwrst.gnt", {31'd0, cGnt}, 32'd1);
    @(negedge clk);
    cReq = 1'b0;
    @(negedge clk); #1;
    checkOutput("rmwrst.we", {31'd0, memWe}, 32'd1);
    checkOutput("rmwrst.wdata", memWdata, 32'h1234BEEF);
    #1 rstN = 1'b0;
    #1;
    checkOutput("rmwrst.weasync", {31'd0, memWe}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    sawRvalid = 1'b0;
    repeat (3) begin
      #1;
      sawRvalid = sawRvalid | cRvalid;
      @(negedge clk);
    end
    checkOutput("rmwrst.norvalid", {31'd0, sawRvalid}, 32'd0);
    checkOutput("rmwrst.mem", tbMem[16], 32'h12345678);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 12'h040, 32'h0);
    checkLoad("lw040", 32'h12345678);

    // Both ports requesting every cycle from a fresh reset
    @(negedge clk); rstN = 1'b0;
    @(negedge clk); rstN = 1'b1;
    @(negedge clk);
    cReq = 1'b1; cWe = 1'b0; cSize = 2'b10; cUns = 1'b0; cAddr = 12'h030;
    dReq = 1'b1; dWe = 1'b0; dAddr = 12'h010;
    for (int i = 0; i < 6; i++) begin
      #1;
      seqCg[i] = cGnt; seqDg[i] = dGnt; seqCv[i] = cRvalid; seqDv[i] = dRvalid;
      seqCd[i] = cRdata; seqDd[i] = dRdata;
      @(negedge clk);
    end
    cReq = 1'b0; dReq = 1'b0;
`ifdef DMEM_CTRL_DBG_PORT_EN
    checkOutput("rr.cgnt", {26'd0, seqCg}, 32'b010001);
    checkOutput("rr.dgnt", {26'd0, seqDg}, 32'b000100);
    checkOutput("rr.crv",  {26'd0, seqCv}, 32'b000100);
    checkOutput("rr.drv",  {26'd0, seqDv}, 32'b010000);
    checkOutput("rr.cdata", seqCd[2], 32'h8000FF80);
    checkOutput("rr.ddata", seqDd[4], 32'h11223344);
`else
    checkOutput("solo.cgnt", {26'd0, seqCg}, 32'b010101);
    checkOutput("solo.dgnt", {26'd0, seqDg}, 32'd0);
    checkOutput("solo.crv",  {26'd0, seqCv}, 32'b010100);
    checkOutput("solo.drv",  {26'd0, seqDv}, 32'd0);
    checkOutput("solo.cdata", seqCd[2], 32'h8000FF80);
    checkOutput("solo.ddata", seqDd[4], 32'h0);
`endif
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Sequencing and arbitration front-end for the word-wide data memory. Accepts RV32I load/store requests from the core LSU (byte, half, word; signed or unsigned loads) and word-only requests from the debug/program-loader port, arbitrates round-robin, and drives the memory's single write-enable/address/data port. Sub-word stores become read-modify-write sequences, because the memory only writes whole words. Loads are aligned and sign- or zero-extended before they return to the core.

## Interface
- DATA_WIDTH: taken from pkg_config, 32. Data path width.
- ADDR_WIDTH: default 12. Byte-address width; 4 KiB covers 1024 words.
- clk_i  in  1  Clock. All state updates on the rising edge.
- rst_ni  in  1  Reset. Asynchronous, active-low.
- c_req_i  in  1  Core request valid. Held until granted.
- c_we_i  in  1  Core store (1) or load (0).
- c_size_i  in  2  Access size: 00 byte, 01 half, 10 word, 11 illegal.
- c_unsigned_i  in  1  Zero-extend a load (LBU/LHU).
- c_addr_i  in  ADDR_WIDTH  Core byte address.
- c_wdata_i  in  DATA_WIDTH  Store data, right-aligned (LSBs).
- c_gnt_o  out  1  Core request accepted this cycle.
- c_rvalid_o  out  1  One-cycle completion pulse for a load or store.
- c_rdata_o  out  DATA_WIDTH  Extended load data. Valid with c_rvalid_o; 0 for stores.
- c_err_o  out  1  Misaligned or illegal-size access. Pulses with c_rvalid_o.
- d_req_i  in  1  Debug request valid.
- d_we_i  in  1  Debug word write (1) or read (0).
- d_addr_i  in  ADDR_WIDTH  Debug byte address. Bits [1:0] are ignored.
- d_wdata_i  in  DATA_WIDTH  Debug write word.
- d_gnt_o  out  1  Debug request accepted.
- d_rvalid_o  out  1  Debug completion pulse.
- d_rdata_o  out  DATA_WIDTH  Debug read word.
- mem_we_o  out  1  Memory write enable.
- mem_addr_o  out  ADDR_WIDTH  Memory byte address, always word-aligned ([1:0]=00).
- mem_wdata_o  out  DATA_WIDTH  Memory write data.
- mem_rdata_i  in  DATA_WIDTH  Memory read data. Combinational from mem_addr_o.

## Operation
- FSM states: IDLE, ACCESS, MERGE_WR.
- IDLE:
  - Grants are combinational, and only in IDLE; at most one grant per cycle.
  - On grant, latch requester ID, we, size, unsigned, address and wdata, then go to ACCESS.
- Arbitration:
  - If only one requester is active, it wins.
  - If both are active, the one not granted last wins. The rr_last flag updates on every grant.
  - After reset, the core wins the first conflict.
- ACCESS, load or debug read: capture mem_rdata_i, format it, return to IDLE.
- ACCESS, word store or debug write: mem_we_o=1 with the latched data, return to IDLE.
- ACCESS, byte/half store: capture mem_rdata_i, merge the data lane, go to MERGE_WR.
  - Byte lane is addr[1:0]; half lane is addr[1].
- MERGE_WR: mem_we_o=1 with the merged word, return to IDLE.
- Misaligned or illegal core access:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠00; illegal means size 11.
  - The request is granted, ACCESS performs no memory write, and completion reports c_err_o=1 with c_rdata_o=0.
- Load formatting:
  - Shift the selected lane down to the LSBs.
  - Sign-extend bit 7 or bit 15 unless unsigned; a word passes through unchanged.
- Debug accesses are always word-sized; d_addr_i[1:0] is forced to 00.
- mem_addr_o: latched address with [1:0]=00 in ACCESS and MERGE_WR; 0 in IDLE.
- mem_we_o is decoded from the state register and is never asserted in IDLE.

## Timing
- Request presented and granted in cycle N.
- Word load, word store, debug access and error: memory cycle N+1, rvalid/err pulse N+2.
- Sub-word store: read N+1, write N+2, rvalid pulse N+3.
- Completion pulses are registered and last exactly one cycle, for the requester latched at grant.
- A new grant may occur in the same cycle as a completion pulse.
- Throughput: one access per 2 cycles (word) or 3 cycles (sub-word).
- Reset values: state=IDLE, rr_last=debug; every output is 0, including all gnt, rvalid, err, rdata, mem_we_o, mem_addr_o and mem_wdata_o.
- Reset asserted mid-operation: immediate return to IDLE and mem_we_o drops asynchronously.
  - The pending RMW write is discarded and no completion pulse is issued; memory keeps the pre-merge word.
- A requester that drops req before its grant loses nothing; no request is ever latched without a grant.

## Configuration
- DMEM_CTRL_DBG_PORT_EN defined: debug port and round-robin arbitration are active as described.
- Undefined:
  - d_* inputs are ignored.
  - d_gnt_o, d_rvalid_o and d_rdata_o are tied to 0.
  - The core is the only requester and rr_last logic is removed.
  - Core timing is unchanged.

## Test plan
- Debug writes 0x11223344 to 0x010, then core runs LB at 0x013 -> c_rdata_o=0x00000011 at N+2; LB at 0x010 -> 0x00000044.
- Memory word 0x000000F0 at 0x020, core SB 0x5A at 0x021 -> mem_we_o only at N+2 with mem_wdata_o=0x00005AF0; rvalid at N+3. Then LB 0x021 -> 0x0000005A, LBU/LH checks.
- Word 0x8000FF80 at 0x030: LH 0x032 -> 0xFFFF8000; LHU 0x032 -> 0x00008000; LB 0x030 -> 0xFFFFFF80.
- Core LW at 0x006 -> c_err_o=1, c_rvalid_o=1 at N+2, c_rdata_o=0, no mem_we_o pulse; same result for size 11.
- Core and debug requesting every cycle from reset -> grants alternate core, debug, core; each rvalid goes only to its own requester.
- Reset asserted during MERGE_WR of SH 0xBEEF at 0x040 (old word 0x12345678) -> mem_we_o falls immediately, no rvalid; a later read returns 0x12345678.
